// File: rtl/event_rate_meter_pkg.sv
// Shared state encoding and default widths for the event rate meter.
package event_rate_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam int DEF_CNT_WIDTH    = 32;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_GATE_TIMEOUT = 48000000;

endpackage

// File: rtl/event_rate_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// rising-edge detector that emits a one-cycle pulse in the i_clk domain.
module sync_edge_detect
    import event_rate_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    // Fewer than two stages gives no metastability protection, so clamp.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/event_rate_meter.sv
// Counts EVENT_IN rising edges between successive GATE_CE strobes.
// Optional gate-loss watchdog enabled by defining RATE_METER_WATCHDOG_EN.
module event_rate_meter
    import event_rate_meter_pkg::*;
#(
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 EVENT_IN,
    input  logic                 GATE_CE,
    input  logic                 ENABLE,
    output logic [CNT_WIDTH-1:0] RATE,
    output logic                 RATE_VALID,
    output logic                 RATE_OVERFLOW,
    output logic                 GATE_ACTIVE
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_rise;
    logic                 w_counting;
    logic                 w_timeout;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 r_ovf;
    logic                 w_ovf_next;
    logic [CNT_WIDTH-1:0] r_rate;
    logic                 r_rate_ovf;
    logic                 r_valid;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_async (EVENT_IN),
        .o_rise  (w_rise)
    );

    assign w_counting = ENABLE && (r_state == COUNT);

`ifdef RATE_METER_WATCHDOG_EN
    localparam int WD_W = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(GATE_TIMEOUT - 1);

    logic [WD_W-1:0] r_wd_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wd_cnt <= '0;
        end else if (!w_counting || GATE_CE || w_timeout) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = w_counting && !GATE_CE && (r_wd_cnt == WD_LAST);
`else
    // Timeout never fires without the watchdog; the parameter is inert.
    assign w_timeout = 1'b0 & (GATE_TIMEOUT == 0);
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!ENABLE) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = ARM;
                ARM:     if (GATE_CE) w_state_next = COUNT;
                COUNT:   if (w_timeout) w_state_next = ARM;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // An edge seen on the closing strobe still belongs to the closing window.
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_cnt_next = w_rise ? w_cnt_inc : r_cnt;
    assign w_ovf_next = r_ovf | (w_rise & (w_cnt_inc == CNT_MAX));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_rate     <= '0;
            r_rate_ovf <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!w_counting) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (GATE_CE) begin
                r_rate     <= w_cnt_next;
                r_rate_ovf <= w_ovf_next;
                r_valid    <= 1'b1;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else if (w_timeout) begin
                r_rate     <= '0;
                r_rate_ovf <= 1'b0;
                r_valid    <= 1'b1;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_next;
            end
        end
    end

    assign RATE          = r_rate;
    assign RATE_OVERFLOW = r_rate_ovf;
    assign RATE_VALID    = r_valid;
    assign GATE_ACTIVE   = (r_state == COUNT);

endmodule

// File: tb/tb_event_rate_meter.sv
// Directed bench for event_rate_meter: a 32-bit and an 8-bit instance share
// the same stimulus so saturation can be compared against the true count.
module tb_event_rate_meter;

    logic        CLK;
    logic        RESET_N;
    logic        EVENT_IN;
    logic        GATE_CE;
    logic        ENABLE;
    logic [31:0] rate32;
    logic        valid32, ovf32, active32;
    logic [7:0]  rate8;
    logic        valid8, ovf8, active8;

    int n_tests = 0;
    int n_fail  = 0;

    event_rate_meter #(
        .CNT_WIDTH    (32),
        .SYNC_STAGES  (2),
        .GATE_TIMEOUT (500)
    ) u_dut32 (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .EVENT_IN      (EVENT_IN),
        .GATE_CE       (GATE_CE),
        .ENABLE        (ENABLE),
        .RATE          (rate32),
        .RATE_VALID    (valid32),
        .RATE_OVERFLOW (ovf32),
        .GATE_ACTIVE   (active32)
    );

    event_rate_meter #(
        .CNT_WIDTH    (8),
        .SYNC_STAGES  (2),
        .GATE_TIMEOUT (500)
    ) u_dut8 (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .EVENT_IN      (EVENT_IN),
        .GATE_CE       (GATE_CE),
        .ENABLE        (ENABLE),
        .RATE          (rate8),
        .RATE_VALID    (valid8),
        .RATE_OVERFLOW (ovf8),
        .GATE_ACTIVE   (active8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2ms;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic gate_pulse();
        GATE_CE = 1'b1;
        step();
        GATE_CE = 1'b0;
    endtask

    task automatic events(input int n, input int half, input int pad);
        for (int i = 0; i < n; i++) begin
            EVENT_IN = 1'b1;
            repeat (half) step();
            EVENT_IN = 1'b0;
            repeat (half) step();
        end
        repeat (pad) step();
    endtask

    // Called right after gate_pulse: result is visible now, pulse gone next cycle.
    task automatic expect_window(input string tag, input int exp32, input int exp8,
                                 input bit eovf32, input bit eovf8);
        check({tag, "_valid32"}, valid32, 1);
        check({tag, "_valid8"}, valid8, 1);
        check({tag, "_rate32"}, rate32, exp32);
        check({tag, "_rate8"}, rate8, exp8);
        check({tag, "_ovf32"}, ovf32, eovf32);
        check({tag, "_ovf8"}, ovf8, eovf8);
        step();
        check({tag, "_pulse_end"}, valid32, 0);
    endtask

    initial begin
        int seen;
        RESET_N  = 1'b0;
        ENABLE   = 1'b0;
        GATE_CE  = 1'b0;
        EVENT_IN = 1'b0;
        #23;
        check("rst_rate32", rate32, 0);
        check("rst_rate8", rate8, 0);
        check("rst_valid", valid32, 0);
        check("rst_ovf", ovf8, 0);
        check("rst_active", active32, 0);
        RESET_N = 1'b1;
        step();

        // Arming: events before the first strobe are discarded
        ENABLE = 1'b1;
        step();
        check("arm_inactive", active32, 0);
        events(3, 5, 4);
        gate_pulse();
        check("arm_no_valid", valid32, 0);
        check("arm_active", active8, 1);

        // Steady windows: 100 edges of period 10 per window
        for (int w = 0; w < 3; w++) begin
            events(100, 5, 0);
            gate_pulse();
            expect_window("w100", 100, 100, 0, 0);
        end

        // Edge reaching the detector on the strobe cycle closes with that window
        EVENT_IN = 1'b1;
        step();
        step();
        gate_pulse();
        expect_window("edge_on_gate", 1, 1, 0, 0);
        repeat (3) step();
        EVENT_IN = 1'b0;
        repeat (20) step();
        gate_pulse();
        expect_window("after_edge", 0, 0, 0, 0);

        // Back-to-back strobes
        events(4, 5, 4);
        gate_pulse();
        check("b2b_first_rate", rate32, 4);
        gate_pulse();
        check("b2b_second_valid", valid32, 1);
        check("b2b_second_rate", rate32, 0);
        step();

        // Saturation on the 8-bit instance, then recovery
        events(300, 2, 4);
        gate_pulse();
        expect_window("sat", 300, 255, 0, 1);
        events(5, 5, 4);
        gate_pulse();
        expect_window("post_sat", 5, 5, 0, 0);

        // ENABLE dropped mid-window
        events(40, 5, 0);
        ENABLE = 1'b0;
        step();
        check("dis_active", active32, 0);
        check("dis_valid", valid32, 0);
        check("dis_rate_hold", rate32, 5);
        repeat (3) step();
        gate_pulse();
        check("dis_gate_valid", valid32, 0);
        check("dis_gate_rate", rate8, 5);
        ENABLE = 1'b1;
        step();
        events(7, 5, 4);
        gate_pulse();
        check("reen_arm_valid", valid32, 0);
        check("reen_arm_active", active32, 1);
        check("reen_arm_rate", rate32, 5);
        events(20, 5, 4);
        gate_pulse();
        expect_window("reen", 20, 20, 0, 0);

        // Reset mid-window after a saturated result
        events(300, 2, 4);
        gate_pulse();
        expect_window("sat2", 300, 255, 0, 1);
        events(10, 5, 0);
        RESET_N = 1'b0;
        #2;
        check("mid_rst_rate32", rate32, 0);
        check("mid_rst_rate8", rate8, 0);
        check("mid_rst_ovf8", ovf8, 0);
        check("mid_rst_active", active32, 0);
        check("mid_rst_valid", valid8, 0);
        repeat (3) step();
        RESET_N = 1'b1;
        step();
        check("post_rst_inactive", active32, 0);
        events(4, 5, 4);
        gate_pulse();
        check("post_rst_arm_valid", valid32, 0);
        check("post_rst_arm_active", active32, 1);
        events(30, 5, 4);
        gate_pulse();
        expect_window("post_rst", 30, 30, 0, 0);

        // Gate stops
        events(12, 5, 4);
        gate_pulse();
        expect_window("pre_stop", 12, 12, 0, 0);
`ifdef RATE_METER_WATCHDOG_EN
        seen = 0;
        repeat (498) begin
            step();
            if (valid32 === 1'b1) seen++;
        end
        check("wd_quiet", seen, 0);
        step();
        check("wd_valid", valid32, 1);
        check("wd_rate32", rate32, 0);
        check("wd_rate8", rate8, 0);
        check("wd_ovf", ovf32, 0);
        check("wd_active", active32, 0);
        step();
        check("wd_pulse_end", valid32, 0);
        gate_pulse();
        check("wd_rearm_valid", valid32, 0);
        events(15, 5, 4);
        gate_pulse();
        expect_window("wd_resume", 15, 15, 0, 0);
`else
        seen = 0;
        repeat (600) begin
            step();
            if (valid32 === 1'b1) seen++;
        end
        check("nogate_quiet", seen, 0);
        check("nogate_rate_hold", rate32, 12);
        check("nogate_active", active32, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
